spr_exception_stack_unit: RTL and testbench
===========================================

// Module: spr_exception_stack_unit
// PURPOSE
//  Parametrised special-purpose-register unit for the single-core CPU. It holds
//  NUM_VECTORS programmable exception vectors and a nested exception stack of
//  {cause, EPC} entries, pushed on exception entry and popped on return-from-exception.
//  It sits beside the execute stage: it supplies the SPR read mux and exceptionVector,
//  and returnPc for the rfe path.
// PARAMETERS
//  NUM_VECTORS  5         programmable vectors, SPR 0x01..NUM_VECTORS (max 15)
//  MODE_W       3         width of exeExcepMode; 2**MODE_W > NUM_VECTORS
//  VEC_W        28        writable low bits of each vector; upper 32-VEC_W = {exceptionPrefix}
//  STACK_DEPTH  4         nested exception entries (>=1)
//  RESET_VEC    28'd48    fixed vector; SPR 0x00 and any out-of-range mode
// PORTS
//  cpuClock         in   1       clock
//  cpuReset         in   1       synchronous, active-high reset
//  stall            in   1       pipeline stall; blocks push, pop and SPR writes
//  sprIndex         in   16      SPR address
//  sprWe            in   1       SPR write strobe
//  sprDataIn        in   32      SPR write data
//  sprDataOut       out  32      SPR read data, combinational from sprIndex
//  exeExcepMode     in   MODE_W  exception cause in execute; 0 = none
//  exceptionPc      in   32      PC saved as EPC on push
//  rfe              in   1       return-from-exception in execute
//  exceptionPrefix  in   1       replicated into upper vector bits
//  exceptionVector  out  32      combinational vector for exeExcepMode
//  returnPc         out  32      EPC of top entry; 0 when stack empty
//  excDepth         out  $clog2(STACK_DEPTH+1)  current stack depth
// BEHAVIOUR
//  - Reset: vector i = 8*i; depth = 0; ovf/unf flags = 0; stack entries = 0.
//  - Outputs at reset: returnPc = 0; excDepth = 0.
//  - Push: when exeExcepMode!=0 && !stall, {mode,exceptionPc} is written at top.
//    Visible on returnPc/excDepth the next cycle.
//  - Push when full: the top entry is overwritten, depth stays at STACK_DEPTH, sticky ovf=1.
//  - Pop: when rfe && !stall && depth>0, depth-1. Pop when empty: no change, sticky unf=1.
//  - Push and pop in the same cycle: the top entry is replaced, depth unchanged.
//    If the stack is empty, this is a plain push and unf is not set.
//  - exceptionVector: {{32-VEC_W{prefix}}, vec[mode]} for 1<=mode<=NUM_VECTORS.
//    Otherwise it is {prefix.., RESET_VEC}.
//  - SPR map (sprIndex[15:8]==0, otherwise reads return 0 and writes are ignored):
//    0x00     RO  {prefix.., RESET_VEC}
//    0x01..N  RW  vector i; a write takes sprDataIn[VEC_W-1:0]
//    0x12     RO  top cause, zero-extended; 0 when empty
//    0x13     RW  top EPC; a write (handler skip) is ignored when empty
//    0x14     status {..0, unf[9], ovf[8], depth[7:0]}
//             write 1 to bit 8 or 9 clears that flag; depth is read-only
//    unmapped reads return 0
//  - SPR writes take effect only when sprWe && !stall, visible one cycle later.
//  - A 0x13 write and a push in the same cycle: the push wins.
//  - A 0x14 clear and a new set in the same cycle: the set wins.
//  - Reset mid-exception: cpuReset dominates everything; the stack is discarded.
// CONFIGURATION
//  SPR_CYCLE_COUNTER_EN defined:
//    - 64-bit cycle counter, reset 0, increments every cycle including stall.
//    - SPR 0x20 = low word, 0x21 = high word, both RW.
//    - A write (when !stall) loads that half; the counter does not increment that cycle.
//    - Low-word wrap carries into the high word.
//  SPR_CYCLE_COUNTER_EN undefined: 0x20/0x21 read 0, writes are ignored, no counter flops.
// TESTING
//  1. Reset, then read SPR 1..5.
//     -> 0x08,0x10,0x18,0x20,0x28; excDepth=0; returnPc=0.
//  2. Write SPR3=0x0ABCDEF0 with prefix=1, then mode=3.
//     -> exceptionVector=0xFABCDEF0.
//  3. Push mode=2 pc=0x100, then mode=4 pc=0x200.
//     -> depth 2, SPR 0x12=4, returnPc=0x200.
//     rfe -> returnPc=0x100, SPR 0x12=2.
//  4. Push 5x with STACK_DEPTH=4.
//     -> depth 4, SPR 0x14 bit8=1, top EPC = 5th PC.
//     Write 0x100 to 0x14 -> bit8=0.
//  5. rfe when empty -> unf=1, depth 0.
//     rfe and mode=1 in the same cycle at depth 1 -> depth 1, cause=1.
//     Exception with stall=1 -> no push.
//  6. With SPR_CYCLE_COUNTER_EN: write 0x20=0xFFFFFFFE, 0x21=0, run 3 cycles.
//     -> lo=0x00000001, hi=1.

Source files
------------

// File: rtl/spr_exception_stack_unit.sv
// ---------------------------------------------------------------------------
// spr_exception_stack_unit
//
// Special-purpose-register unit for the single-core CPU. Holds NUM_VECTORS
// programmable exception vectors and a nested exception stack of
// {cause, EPC} entries. The execute stage pushes an entry on exception entry
// and pops it on return-from-exception (rfe).
//
// Ports
//   cpuClock         clock
//   cpuReset         synchronous, active-high reset
//   stall            pipeline stall; blocks push, pop and SPR writes
//   sprIndex         SPR address (upper byte must be zero to hit the map)
//   sprWe/sprDataIn  SPR write strobe and data
//   sprDataOut       SPR read data, combinational from sprIndex
//   exeExcepMode     exception cause in execute, 0 = none
//   exceptionPc      PC saved as EPC on push
//   rfe              return-from-exception in execute
//   exceptionPrefix  replicated into the upper vector bits
//   exceptionVector  combinational handler address for exeExcepMode
//   returnPc         EPC of the top entry, 0 when the stack is empty
//   excDepth         current stack depth
//
// SPR map: 0x00 reset vector (RO), 0x01..N vectors, 0x12 top cause (RO),
// 0x13 top EPC, 0x14 status {unf[9], ovf[8], depth[7:0]},
// 0x20/0x21 cycle counter low/high.
//
// Build option SPR_CYCLE_COUNTER_EN: adds a 64-bit free-running cycle
// counter at SPR 0x20/0x21. Without it those addresses read 0.
// ---------------------------------------------------------------------------
module spr_exception_stack_unit #(
    parameter int              NUM_VECTORS = 5,
    parameter int              MODE_W      = 3,
    parameter int              VEC_W       = 28,
    parameter int              STACK_DEPTH = 4,
    parameter logic [VEC_W-1:0] RESET_VEC  = VEC_W'(48),
    localparam int             DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               cpuClock,
    input  logic               cpuReset,
    input  logic               stall,
    input  logic [15:0]        sprIndex,
    input  logic               sprWe,
    input  logic [31:0]        sprDataIn,
    output logic [31:0]        sprDataOut,
    input  logic [MODE_W-1:0]  exeExcepMode,
    input  logic [31:0]        exceptionPc,
    input  logic               rfe,
    input  logic               exceptionPrefix,
    output logic [31:0]        exceptionVector,
    output logic [31:0]        returnPc,
    output logic [DEPTH_W-1:0] excDepth
);

    localparam int PFX_W = 32 - VEC_W;
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [VEC_W-1:0]   vec_q   [1:NUM_VECTORS];
    logic [MODE_W-1:0]  cause_q [STACK_DEPTH];
    logic [31:0]        epc_q   [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic               ovf_q;
    logic               unf_q;

    logic               push;
    logic               pop_req;
    logic               empty;
    logic               full;
    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   slot;
    logic [DEPTH_W-1:0] depth_d;
    logic               ovf_set;
    logic               unf_set;
    logic [MODE_W-1:0]  top_cause;
    logic [31:0]        top_epc;
    logic [PFX_W-1:0]   pfx;
    logic [VEC_W-1:0]   vec_sel;
    logic               spr_hit;
    logic [7:0]         spr_addr;
    logic               spr_wr;

    assign push     = (exeExcepMode != '0) && !stall;
    assign pop_req  = rfe && !stall;
    assign empty    = (depth_q == '0);
    assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign top_idx  = IDX_W'(depth_q - 1'b1);
    assign pfx      = {PFX_W{exceptionPrefix}};
    assign spr_hit  = (sprIndex[15:8] == 8'h00);
    assign spr_addr = sprIndex[7:0];
    assign spr_wr   = sprWe && !stall && spr_hit;

    assign top_cause = empty ? '0 : cause_q[top_idx];
    assign top_epc   = empty ? '0 : epc_q[top_idx];

    // Stack control. A push that coincides with a pop replaces the top entry;
    // on an empty stack there is nothing to replace, so it degrades to a push.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch cannot be inferred.
        depth_d = depth_q;
        slot    = top_idx;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (push) begin
            if (pop_req && !empty) begin
                slot = top_idx;
            end else if (full) begin
                ovf_set = 1'b1;
            end else begin
                slot    = IDX_W'(depth_q);
                depth_d = depth_q + 1'b1;
            end
        end else if (pop_req) begin
            if (empty) unf_set = 1'b1;
            else       depth_d = depth_q - 1'b1;
        end
    end

    always_comb begin
        vec_sel = RESET_VEC;
        for (int i = 1; i <= NUM_VECTORS; i++) begin
            if (exeExcepMode == MODE_W'(i)) vec_sel = vec_q[i];
        end
    end

    assign exceptionVector = {pfx, vec_sel};
    assign returnPc        = top_epc;
    assign excDepth        = depth_q;

    `ifdef SPR_CYCLE_COUNTER_EN
    logic [63:0] cnt_q;

    // Free-running, stall-independent. A software load replaces one half and
    // suppresses that cycle's increment so the written value reads back intact.
    always_ff @(posedge cpuClock) begin
        if (cpuReset)                          cnt_q <= '0;
        else if (spr_wr && spr_addr == 8'h20)  cnt_q[31:0]  <= sprDataIn;
        else if (spr_wr && spr_addr == 8'h21)  cnt_q[63:32] <= sprDataIn;
        else                                   cnt_q <= cnt_q + 64'd1;
    end
    `endif

    always_comb begin
        sprDataOut = '0;
        if (spr_hit) begin
            case (spr_addr)
                8'h00: sprDataOut = {pfx, RESET_VEC};
                8'h12: sprDataOut = 32'(top_cause);
                8'h13: sprDataOut = top_epc;
                8'h14: sprDataOut = {22'd0, unf_q, ovf_q, 8'(depth_q)};
                `ifdef SPR_CYCLE_COUNTER_EN
                8'h20: sprDataOut = cnt_q[31:0];
                8'h21: sprDataOut = cnt_q[63:32];
                `endif
                default: begin
                    for (int i = 1; i <= NUM_VECTORS; i++) begin
                        if (spr_addr == 8'(i)) sprDataOut = 32'(vec_q[i]);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge cpuClock) begin
        if (cpuReset) begin
            // NOTE: the stack storage is reset too, so a reset in the middle
            // of a handler leaves no stale cause/EPC behind.
            for (int i = 1; i <= NUM_VECTORS; i++) vec_q[i] <= VEC_W'(8 * i);
            for (int i = 0; i < STACK_DEPTH; i++) begin
                cause_q[i] <= '0;
                epc_q[i]   <= '0;
            end
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            for (int i = 1; i <= NUM_VECTORS; i++) begin
                if (spr_wr && spr_addr == 8'(i)) vec_q[i] <= sprDataIn[VEC_W-1:0];
            end
            // Handler EPC skip; a same-cycle push owns the top slot instead.
            if (spr_wr && spr_addr == 8'h13 && !empty && !push)
                epc_q[top_idx] <= sprDataIn;
            if (push) begin
                cause_q[slot] <= exeExcepMode;
                epc_q[slot]   <= exceptionPc;
            end
            depth_q <= depth_d;
            // Sticky flags: a hardware set beats a same-cycle software clear.
            if (ovf_set)                                         ovf_q <= 1'b1;
            else if (spr_wr && spr_addr == 8'h14 && sprDataIn[8]) ovf_q <= 1'b0;
            if (unf_set)                                         unf_q <= 1'b1;
            else if (spr_wr && spr_addr == 8'h14 && sprDataIn[9]) unf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spr_exception_stack_unit.sv
module tb_spr_exception_stack_unit;

    logic        cpuClock = 1'b0;
    logic        cpuReset;
    logic        stall;
    logic [15:0] sprIndex;
    logic        sprWe;
    logic [31:0] sprDataIn;
    logic [31:0] sprDataOut;
    logic [2:0]  exeExcepMode;
    logic [31:0] exceptionPc;
    logic        rfe;
    logic        exceptionPrefix;
    logic [31:0] exceptionVector;
    logic [31:0] returnPc;
    logic [2:0]  excDepth;

    spr_exception_stack_unit dut (
        .cpuClock        (cpuClock),
        .cpuReset        (cpuReset),
        .stall           (stall),
        .sprIndex        (sprIndex),
        .sprWe           (sprWe),
        .sprDataIn       (sprDataIn),
        .sprDataOut      (sprDataOut),
        .exeExcepMode    (exeExcepMode),
        .exceptionPc     (exceptionPc),
        .rfe             (rfe),
        .exceptionPrefix (exceptionPrefix),
        .exceptionVector (exceptionVector),
        .returnPc        (returnPc),
        .excDepth        (excDepth)
    );

    always #5 cpuClock = ~cpuClock;

    // Reference model: vectors as plain integers, the exception stack as a
    // queue whose back is the top entry.
    typedef struct {
        logic [2:0]  cause;
        logic [31:0] epc;
    } entry_t;

    typedef struct {
        logic [15:0] idx;
        logic [31:0] spr;
        logic [31:0] vec;
        logic [31:0] rpc;
        logic [31:0] depth;
    } exp_t;

    int unsigned     m_vec [1:5];
    entry_t          m_stk [$];
    bit              m_ovf;
    bit              m_unf;
    longint unsigned m_cnt;
    exp_t            sb [$];

    int tests  = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
        end
    endtask

    function automatic void model_reset();
        for (int i = 1; i <= 5; i++) m_vec[i] = 8 * i;
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
        m_cnt = 0;
    endfunction

    function automatic exp_t model_expect();
        exp_t        e;
        logic [31:0] pfx;
        int          n;
        int          a;
        n   = m_stk.size();
        a   = int'(sprIndex[7:0]);
        pfx = exceptionPrefix ? 32'hF000_0000 : 32'h0;
        e.idx = sprIndex;
        e.spr = 32'h0;
        if (sprIndex[15:8] == 8'h00) begin
            if (a == 0)                 e.spr = pfx | 32'd48;
            else if (a >= 1 && a <= 5)  e.spr = m_vec[a];
            else if (a == 'h12)         e.spr = (n > 0) ? 32'(m_stk[n-1].cause) : 32'h0;
            else if (a == 'h13)         e.spr = (n > 0) ? m_stk[n-1].epc : 32'h0;
            else if (a == 'h14)         e.spr = (32'(m_unf) << 9) | (32'(m_ovf) << 8) | 32'(n);
            `ifdef SPR_CYCLE_COUNTER_EN
            else if (a == 'h20)         e.spr = m_cnt[31:0];
            else if (a == 'h21)         e.spr = m_cnt[63:32];
            `endif
        end
        if (exeExcepMode >= 1 && exeExcepMode <= 5) e.vec = pfx | m_vec[exeExcepMode];
        else                                        e.vec = pfx | 32'd48;
        e.rpc   = (n > 0) ? m_stk[n-1].epc : 32'h0;
        e.depth = 32'(n);
        return e;
    endfunction

    // Apply one clock edge's worth of architectural rules to the model.
    function automatic void model_step();
        bit     wr, push, pop, cnt_wr;
        int     n, a;
        entry_t t;
        if (cpuReset) begin
            model_reset();
            return;
        end
        wr     = sprWe && !stall && (sprIndex[15:8] == 8'h00);
        a      = int'(sprIndex[7:0]);
        push   = (exeExcepMode != 0) && !stall;
        pop    = rfe && !stall;
        cnt_wr = 0;
        n      = m_stk.size();
        if (wr) begin
            if (a >= 1 && a <= 5) m_vec[a] = sprDataIn & 32'h0FFF_FFFF;
            if (a == 'h13 && n > 0 && !push) begin
                t = m_stk[n-1];
                t.epc = sprDataIn;
                m_stk[n-1] = t;
            end
            if (a == 'h14) begin
                if (sprDataIn[8]) m_ovf = 0;
                if (sprDataIn[9]) m_unf = 0;
            end
            `ifdef SPR_CYCLE_COUNTER_EN
            if (a == 'h20) begin m_cnt = {m_cnt[63:32], sprDataIn}; cnt_wr = 1; end
            if (a == 'h21) begin m_cnt = {sprDataIn, m_cnt[31:0]};  cnt_wr = 1; end
            `endif
        end
        t.cause = exeExcepMode;
        t.epc   = exceptionPc;
        if (push) begin
            if (pop && n > 0)  m_stk[n-1] = t;
            else if (n < 4)    m_stk.push_back(t);
            else begin         m_stk[n-1] = t; m_ovf = 1; end
        end else if (pop) begin
            if (n > 0) void'(m_stk.pop_back());
            else       m_unf = 1;
        end
        if (!cnt_wr) m_cnt = m_cnt + 1;
    endfunction

    // One cycle of stimulus: drive, record the expectation, clock the model.
    task automatic drive(input bit rst, input bit stl, input logic [15:0] idx,
                         input bit we, input logic [31:0] data, input logic [2:0] mode,
                         input logic [31:0] pc, input bit rf, input bit pfx);
        cpuReset        = rst;
        stall           = stl;
        sprIndex        = idx;
        sprWe           = we;
        sprDataIn       = data;
        exeExcepMode    = mode;
        exceptionPc     = pc;
        rfe             = rf;
        exceptionPrefix = pfx;
        sb.push_back(model_expect());
        @(posedge cpuClock);
        model_step();
        #1;
    endtask

    task automatic idle(input logic [15:0] idx, input bit pfx);
        drive(0, 0, idx, 0, 0, 0, 0, 0, pfx);
    endtask

    // Monitor: compare the outputs the DUT presents mid-cycle against the
    // oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge cpuClock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("sprDataOut[%h]", e.idx), sprDataOut, e.spr);
                check("exceptionVector", exceptionVector, e.vec);
                check("returnPc", returnPc, e.rpc);
                check("excDepth", 32'(excDepth), e.depth);
            end
        end
    end

    localparam logic [15:0] IDX_POOL [14] = '{16'h00, 16'h01, 16'h02, 16'h03, 16'h04,
        16'h05, 16'h06, 16'h12, 16'h13, 16'h14, 16'h20, 16'h21, 16'h0113, 16'h15};

    initial begin
        logic [15:0] idx;
        logic [31:0] data;
        logic [2:0]  mode;
        bit          pfx;

        cpuReset = 1; stall = 0; sprIndex = 0; sprWe = 0; sprDataIn = 0;
        exeExcepMode = 0; exceptionPc = 0; rfe = 0; exceptionPrefix = 0;
        @(posedge cpuClock);
        model_reset();
        #1;

        // Reset state and vector readback.
        drive(1, 0, 16'h00, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) idle(16'(i), 0);
        idle(16'h14, 0);

        // Programmed vector with prefix.
        drive(0, 0, 16'h03, 1, 32'h0ABC_DEF0, 0, 0, 0, 1);
        drive(0, 0, 16'h00, 0, 0, 3'd3, 0, 0, 1);
        drive(1, 0, 16'h00, 0, 0, 0, 0, 0, 0);

        // Two nested pushes, then rfe.
        drive(0, 0, 16'h12, 0, 0, 3'd2, 32'h100, 0, 0);
        drive(0, 0, 16'h12, 0, 0, 3'd4, 32'h200, 0, 0);
        idle(16'h12, 0);
        drive(0, 0, 16'h12, 0, 0, 0, 0, 1, 0);
        idle(16'h12, 0);
        drive(1, 0, 16'h00, 0, 0, 0, 0, 0, 0);

        // Overflow and flag clear.
        for (int i = 1; i <= 5; i++) drive(0, 0, 16'h14, 0, 0, 3'd1, 32'(i * 16'h40), 0, 0);
        idle(16'h13, 0);
        drive(0, 0, 16'h14, 1, 32'h100, 0, 0, 0, 0);
        idle(16'h14, 0);
        drive(1, 0, 16'h00, 0, 0, 0, 0, 0, 0);

        // Underflow, push+pop replacement, stalled exception.
        drive(0, 0, 16'h14, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 16'h14, 0, 0, 3'd2, 32'h300, 0, 0);
        drive(0, 0, 16'h12, 0, 0, 3'd1, 32'h400, 1, 0);
        idle(16'h12, 0);
        drive(0, 1, 16'h14, 0, 0, 3'd5, 32'h500, 0, 0);
        idle(16'h14, 0);

        // Cycle counter load and carry into the high word.
        drive(0, 0, 16'h20, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        drive(0, 0, 16'h21, 1, 32'h0, 0, 0, 0, 0);
        idle(16'h20, 0);
        idle(16'h20, 0);
        idle(16'h20, 0);
        idle(16'h21, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            idx  = IDX_POOL[$urandom_range(0, 13)];
            data = $urandom;
            if (idx == 16'h14) data = {22'd0, 1'($urandom), 1'($urandom), 8'($urandom)};
            mode = ($urandom_range(0, 9) < 4) ? 3'($urandom_range(1, 7)) : 3'd0;
            pfx  = ($urandom_range(0, 1) == 1) && !(idx >= 16'h01 && idx <= 16'h05);
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 6) == 0, idx,
                  $urandom_range(0, 9) < 3, data, mode, $urandom, $urandom_range(0, 3) == 0, pfx);
        end

        for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge cpuClock);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
